// File: rtl/gbsha_fir_prog.sv
// Programmable-coefficient FIR filter with a sequential multiply-accumulate engine (one tap per clock).
// Each result is arithmetically shifted, saturated to the output width, and any clipping sets a sticky flag.
module gbsha_fir_prog #(
  parameter int N_TAPS  = 4,
  parameter int BW_IN   = 4,
  parameter int BW_COEF = 4,
  parameter int BW_OUT  = 8,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [BW_IN-1:0]   x_in,
  input  logic                      valid_in,
  input  logic signed [BW_COEF-1:0] coef_in,
  input  logic                      coef_we,
  output logic signed [BW_OUT-1:0]  y_out,
  output logic                      valid_out,
  output logic                      busy,
  output logic                      sat
);

  localparam int BW_PROD = BW_IN + BW_COEF;
  localparam int BW_ACC  = BW_PROD + $clog2(N_TAPS);
  localparam int IDXW    = $clog2(N_TAPS);
  localparam int BW_WIDE = BW_ACC + BW_OUT;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_TAPS - 1);
  localparam logic signed [BW_WIDE-1:0] MAX_POS = {{(BW_WIDE-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
  localparam logic signed [BW_WIDE-1:0] MIN_NEG = {{(BW_WIDE-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

  typedef enum logic {IDLE, MAC} state_t;

  state_t                     r_state;
  state_t                     w_stateNext;
  logic signed [BW_IN-1:0]    r_x [N_TAPS];
  logic signed [BW_COEF-1:0]  r_c [N_TAPS];
  logic signed [BW_ACC-1:0]   r_acc;
  logic [IDXW-1:0]            r_idx;
  logic signed [BW_OUT-1:0]   r_yOut;
  logic                       r_validOut;
  logic                       r_sat;

  logic                       w_load;
  logic                       w_accept;
  logic                       w_last;
  logic signed [BW_PROD-1:0]  w_cExt;
  logic signed [BW_PROD-1:0]  w_xExt;
  logic signed [BW_PROD-1:0]  w_prod;
  logic signed [BW_ACC-1:0]   w_sum;
  logic signed [BW_ACC-1:0]   w_shifted;
  logic signed [BW_WIDE-1:0]  w_wide;
  logic signed [BW_OUT-1:0]   w_yNext;
  logic                       w_satHit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Coefficient writes win over samples; both are ignored while the MAC runs.
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (coef_we) begin
          w_load = 1'b1;
        end else if (valid_in) begin
          w_accept    = 1'b1;
          w_stateNext = MAC;
        end
      end
      MAC: begin
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Sum is widened by BW_OUT bits so the clamp compare works for any SHIFT/BW_OUT mix.
  always_comb begin
    w_cExt    = {{BW_IN{r_c[r_idx][BW_COEF-1]}}, r_c[r_idx]};
    w_xExt    = {{BW_COEF{r_x[r_idx][BW_IN-1]}}, r_x[r_idx]};
    w_prod    = w_cExt * w_xExt;
    w_sum     = r_acc + {{(BW_ACC-BW_PROD){w_prod[BW_PROD-1]}}, w_prod};
    w_shifted = w_sum >>> SHIFT;
    w_wide    = {{BW_OUT{w_shifted[BW_ACC-1]}}, w_shifted};
    w_satHit  = 1'b0;
    if (w_wide > MAX_POS) begin
      w_yNext  = {1'b0, {(BW_OUT-1){1'b1}}};
      w_satHit = 1'b1;
    end else if (w_wide < MIN_NEG) begin
      w_yNext  = {1'b1, {(BW_OUT-1){1'b0}}};
      w_satHit = 1'b1;
    end else begin
      w_yNext = w_wide[BW_OUT-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_x[k] <= '0;
        r_c[k] <= '0;
      end
      r_acc      <= '0;
      r_idx      <= '0;
      r_yOut     <= '0;
      r_validOut <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_validOut <= 1'b0;
      if (w_load) begin
        r_c[0] <= coef_in;
        for (int k = 1; k < N_TAPS; k++) r_c[k] <= r_c[k-1];
      end
      if (w_accept) begin
        r_x[0] <= x_in;
        for (int k = 1; k < N_TAPS; k++) r_x[k] <= r_x[k-1];
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= w_sum;
        r_idx <= r_idx + 1'b1;
        if (w_last) begin
          r_yOut     <= w_yNext;
          r_validOut <= 1'b1;
          if (w_satHit) r_sat <= 1'b1;
        end
      end
    end
  end

  assign y_out     = r_yOut;
  assign valid_out = r_validOut;
  assign busy      = (r_state == MAC);
  assign sat       = r_sat;

endmodule
